// File: rtl/keycode_move_decoder_if.sv
// rtl/keycode_move_decoder_if.sv - move command handshake between the key decoder and game logic
interface keycode_move_decoder_if;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ack;

  modport master (output move_valid, output move_dir, input move_ack);
  modport slave  (input move_valid, input move_dir, output move_ack);
endinterface

// File: rtl/keycode_move_decoder.sv
// rtl/keycode_move_decoder.sv - USB keycode to move commands with auto-repeat, pause and start
// Key state is sampled once per frame tick; moves go through a one-entry buffer.
module keycode_move_decoder #(
  parameter int unsigned REPEAT_DELAY  = 20,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic [15:0]            keycode,
  keycode_move_decoder_if.master move,
  output logic                   paused,
  output logic                   start_pulse,
  output logic [7:0]             drop_count
);
  localparam logic [5:0] DELAY_LOAD  = 6'(REPEAT_DELAY);
  localparam logic [5:0] PERIOD_LOAD = 6'(REPEAT_PERIOD);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t     state, state_next;
  logic [5:0] count, count_next;
  logic [1:0] dir, dir_next;
  logic       frame_sync1, frame_sync2, frame_prev;
  logic       tick;
  logic       space_prev, enter_prev;
  logic       space_now, enter_now, space_edge, enter_edge;
  logic [2:0] dir_slot0, dir_slot1;
  logic       key_has_dir;
  logic [1:0] key_dir;
  logic       gen;

  // {present, direction}
  function automatic logic [2:0] decode_dir(input logic [7:0] code);
    case (code)
      8'h1A, 8'h52: decode_dir = 3'b100;
      8'h16, 8'h51: decode_dir = 3'b101;
      8'h04, 8'h50: decode_dir = 3'b110;
      8'h07, 8'h4F: decode_dir = 3'b111;
      default:      decode_dir = 3'b000;
    endcase
  endfunction

  assign tick        = frame_sync2 & ~frame_prev;
  assign dir_slot0   = decode_dir(keycode[7:0]);
  assign dir_slot1   = decode_dir(keycode[15:8]);
  assign key_has_dir = dir_slot0[2] | dir_slot1[2];
  assign key_dir     = dir_slot0[2] ? dir_slot0[1:0] : dir_slot1[1:0];
  assign space_now   = (keycode[7:0] == 8'h2C) || (keycode[15:8] == 8'h2C);
  assign enter_now   = (keycode[7:0] == 8'h28) || (keycode[15:8] == 8'h28);
  assign space_edge  = tick & space_now & ~space_prev;
  assign enter_edge  = tick & enter_now & ~enter_prev;

  always_comb begin
    state_next = state;
    count_next = count;
    dir_next   = dir;
    gen        = 1'b0;
    if (paused) begin
      state_next = IDLE;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (key_has_dir) begin
            gen        = 1'b1;
            count_next = DELAY_LOAD;
            dir_next   = key_dir;
            state_next = DELAY;
          end
        end
        default: begin
          if (!key_has_dir) begin
            state_next = IDLE;
          end else if (key_dir != dir) begin
            gen        = 1'b1;
            count_next = DELAY_LOAD;
            dir_next   = key_dir;
            state_next = DELAY;
          end else if (count <= 6'd1) begin
            gen        = 1'b1;
            count_next = PERIOD_LOAD;
            state_next = REPEAT;
          end else begin
            count_next = count - 6'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= IDLE;
      count           <= 6'd0;
      dir             <= 2'd0;
      frame_sync1     <= 1'b0;
      frame_sync2     <= 1'b0;
      frame_prev      <= 1'b0;
      space_prev      <= 1'b0;
      enter_prev      <= 1'b0;
      paused          <= 1'b0;
      start_pulse     <= 1'b0;
      drop_count      <= 8'd0;
      move.move_valid <= 1'b0;
      move.move_dir   <= 2'd0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      dir         <= dir_next;
      frame_sync1 <= frame_clk;
      frame_sync2 <= frame_sync1;
      frame_prev  <= frame_sync2;
      start_pulse <= enter_edge;
      if (tick) begin
        space_prev <= space_now;
        enter_prev <= enter_now;
      end
      if (enter_edge) begin
        paused <= 1'b0;
      end else if (space_edge) begin
        paused <= ~paused;
      end
      // A same-cycle ack frees the slot, so the new move is loaded rather than dropped.
      if (gen) begin
        if (move.move_valid && !move.move_ack) begin
          if (drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
          end
        end else begin
          move.move_valid <= 1'b1;
          move.move_dir   <= key_dir;
        end
      end else if (move.move_valid && move.move_ack) begin
        move.move_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_keycode_move_decoder.sv
// tb/tb_keycode_move_decoder.sv - self-checking bench for keycode_move_decoder
module tb_keycode_move_decoder;
  localparam int DELAY  = 20;
  localparam int PERIOD = 8;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [15:0] keycode = 16'h0000;
  logic        paused;
  logic        start_pulse;
  logic [7:0]  drop_count;

  keycode_move_decoder_if mif();

  keycode_move_decoder #(.REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .move(mif.master), .paused(paused), .start_pulse(start_pulse), .drop_count(drop_count)
  );

  always #10 Clk = ~Clk;

  int compared = 0;
  int failed = 0;

  // frame-level reference model: held direction and how many frames it has been held
  int m_held, m_age, m_pending, m_pdir, m_drop, m_paused, m_sp_prev, m_en_prev;
  int m_starts = 0;
  int exp_q[$];
  int consumed_total = 0;
  int sp_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dir_of(input logic [7:0] c);
    case (c)
      8'h1A, 8'h52: return 0;
      8'h16, 8'h51: return 1;
      8'h04, 8'h50: return 2;
      8'h07, 8'h4F: return 3;
      default:      return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_held = -1; m_age = 0; m_pending = 0; m_pdir = 0; m_drop = 0;
    m_paused = 0; m_sp_prev = 0; m_en_prev = 0;
    exp_q.delete();
  endtask

  // mode 0: ack low; mode 1: ack high whole frame; mode 2: ack high only on the tick cycle
  task automatic model_step(input logic [15:0] key, input int mode);
    int d, gen, sp, en;
    logic [7:0] s0, s1;
    s0 = key[7:0];
    s1 = key[15:8];
    d = dir_of(s0);
    if (d < 0) d = dir_of(s1);
    gen = 0;
    if (m_paused != 0 || d < 0) begin
      m_held = -1;
    end else if (d != m_held) begin
      m_held = d; m_age = 0; gen = 1;
    end else begin
      m_age++;
      if (m_age >= DELAY && (m_age - DELAY) % PERIOD == 0) gen = 1;
    end
    case (mode)
      0: begin
        if (gen != 0) begin
          if (m_pending != 0) begin
            if (m_drop < 255) m_drop++;
          end else begin
            m_pending = 1; m_pdir = d;
          end
        end
      end
      1: begin
        if (m_pending != 0) exp_q.push_back(m_pdir);
        m_pending = 0;
        if (gen != 0) exp_q.push_back(d);
      end
      default: begin
        if (m_pending != 0) exp_q.push_back(m_pdir);
        m_pending = gen;
        if (gen != 0) m_pdir = d;
      end
    endcase
    sp = (s0 == 8'h2C || s1 == 8'h2C) ? 1 : 0;
    en = (s0 == 8'h28 || s1 == 8'h28) ? 1 : 0;
    if (en != 0 && m_en_prev == 0) begin
      m_paused = 0; m_starts++;
    end else if (sp != 0 && m_sp_prev == 0) begin
      m_paused = 1 - m_paused;
    end
    m_sp_prev = sp;
    m_en_prev = en;
  endtask

  always @(negedge Clk) begin
    #1;
    if (start_pulse) sp_cnt++;
    if (!Reset && mif.move_valid && mif.move_ack) begin
      consumed_total++;
      if (exp_q.size() == 0) begin
        compared++;
        failed++;
        $display("FAIL unexpected_move: got dir %0d expected no move", mif.move_dir);
      end else begin
        check("consumed_dir", int'(mif.move_dir), exp_q.pop_front());
      end
    end
  end

  task automatic check_state();
    check("move_valid", int'(mif.move_valid), m_pending);
    if (m_pending != 0) check("move_dir", int'(mif.move_dir), m_pdir);
    check("drop_count", int'(drop_count), m_drop);
    check("paused", int'(paused), m_paused);
    check("start_pulses", sp_cnt, m_starts);
    check("moves_outstanding", exp_q.size(), 0);
  endtask

  task automatic run_frame(input logic [15:0] key, input int mode);
    model_step(key, mode);
    @(negedge Clk);
    keycode = key;
    mif.move_ack = (mode == 1);
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    if (mode == 2) mif.move_ack = 1'b1;
    @(negedge Clk);
    if (mode == 2) mif.move_ack = 1'b0;
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    check_state();
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    mif.move_ack = 1'b0;
    frame_clk = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("rst_move_valid", int'(mif.move_valid), 0);
    check("rst_move_dir", int'(mif.move_dir), 0);
    check("rst_paused", int'(paused), 0);
    check("rst_start_pulse", int'(start_pulse), 0);
    check("rst_drop_count", int'(drop_count), 0);
    model_reset();
  endtask

  typedef struct {
    logic [15:0] key;
    int          mode;
    logic        exp_valid;
    logic [1:0]  exp_dir;
    int          exp_drop;
    logic        exp_paused;
    int          exp_moves;
    int          exp_start;
  } vec_t;

  vec_t vecs[12];
  logic [7:0] pool[12];

  initial begin
    int c0, s0;
    logic [15:0] key;

    vecs[0]  = '{16'h0704, 1, 1'b0, 2'd0, 0, 1'b0, 1, 0};
    vecs[1]  = '{16'h0007, 1, 1'b0, 2'd0, 0, 1'b0, 1, 0};
    vecs[2]  = '{16'h0007, 1, 1'b0, 2'd0, 0, 1'b0, 0, 0};
    vecs[3]  = '{16'h0000, 0, 1'b0, 2'd0, 0, 1'b0, 0, 0};
    vecs[4]  = '{16'h001A, 0, 1'b1, 2'd0, 0, 1'b0, 0, 0};
    vecs[5]  = '{16'h0007, 0, 1'b1, 2'd0, 1, 1'b0, 0, 0};
    vecs[6]  = '{16'h0016, 2, 1'b1, 2'd1, 1, 1'b0, 1, 0};
    vecs[7]  = '{16'h2C00, 1, 1'b0, 2'd0, 1, 1'b1, 1, 0};
    vecs[8]  = '{16'h2C1A, 1, 1'b0, 2'd0, 1, 1'b1, 0, 0};
    vecs[9]  = '{16'h001A, 1, 1'b0, 2'd0, 1, 1'b1, 0, 0};
    vecs[10] = '{16'h0028, 1, 1'b0, 2'd0, 1, 1'b0, 0, 1};
    vecs[11] = '{16'h001A, 1, 1'b0, 2'd0, 1, 1'b0, 1, 0};
    pool = '{8'h00, 8'h00, 8'h1A, 8'h52, 8'h16, 8'h51, 8'h04, 8'h50, 8'h07, 8'h4F, 8'h2C, 8'h28};

    mif.move_ack = 1'b0;
    model_reset();
    do_reset();

    // held W with ack tied high: moves after ticks 1, 21, 29, 37 only
    for (int i = 0; i < 40; i++) begin
      c0 = consumed_total;
      run_frame(16'h001A, 1);
      check($sformatf("hold_w_frame%0d", i + 1), consumed_total - c0,
            (i == 0 || i == 20 || i == 28 || i == 36) ? 1 : 0);
    end
    c0 = consumed_total;
    for (int i = 0; i < 3; i++) run_frame(16'h0000, 1);
    check("release_no_moves", consumed_total - c0, 0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      c0 = consumed_total;
      s0 = sp_cnt;
      run_frame(vecs[i].key, vecs[i].mode);
      check($sformatf("vec%0d_valid", i), int'(mif.move_valid), int'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("vec%0d_dir", i), int'(mif.move_dir), int'(vecs[i].exp_dir));
      check($sformatf("vec%0d_drop", i), int'(drop_count), vecs[i].exp_drop);
      check($sformatf("vec%0d_paused", i), int'(paused), int'(vecs[i].exp_paused));
      check($sformatf("vec%0d_moves", i), consumed_total - c0, vecs[i].exp_moves);
      check($sformatf("vec%0d_start", i), sp_cnt - s0, vecs[i].exp_start);
    end

    // ack held low: repeats at ticks 21 and 29 are dropped
    do_reset();
    for (int i = 0; i < 29; i++) run_frame(16'h001A, 0);
    check("noack_drop_29", int'(drop_count), 2);
    check("noack_dir", int'(mif.move_dir), 0);
    for (int i = 0; i < 11; i++) run_frame(16'h001A, 0);
    @(negedge Clk);
    mif.move_ack = 1'b1;
    exp_q.push_back(m_pdir);
    m_pending = 0;
    @(negedge Clk);
    mif.move_ack = 1'b0;
    check("ack_clears_valid", int'(mif.move_valid), 0);

    // reset during REPEAT with a move pending, then fresh press
    do_reset();
    for (int i = 0; i < 21; i++) run_frame(16'h001A, 1);
    for (int i = 0; i < 8; i++) run_frame(16'h001A, 0);
    check("pending_before_reset", int'(mif.move_valid), 1);
    do_reset();
    c0 = consumed_total;
    run_frame(16'h001A, 1);
    check("fresh_after_reset", consumed_total - c0, 1);

    // randomized key holds and ack modes against the model
    do_reset();
    key = 16'h0000;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 8) key = {pool[$urandom_range(0, 11)], pool[$urandom_range(0, 11)]};
      run_frame(key, int'($urandom_range(0, 2)));
    end

    // drop_count saturation
    do_reset();
    for (int i = 0; i < 2120; i++) run_frame(16'h0052, 0);
    check("drop_saturated", int'(drop_count), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule

// File: doc/keycode_move_decoder.md
KEYCODE_MOVE_DECODER -- requirements
Module: keycode_move_decoder

Interface
REQ-001 Parameter REPEAT_DELAY, default 20: frame ticks a direction key must stay held after its first move before auto-repeat starts (range 1..63).
REQ-002 Parameter REPEAT_PERIOD, default 8: frame ticks between auto-repeat moves (range 1..63).
REQ-003 Clk  input  1  system clock, 50 MHz; all logic runs on the rising edge.
REQ-004 Reset  input  1  reset; the block has one clock, and reset is synchronous and active-high.
REQ-005 frame_clk  input  1  VGA vertical sync, asynchronous to the block's logic.
REQ-006 keycode  input  16  USB HID keycodes from the NIOS II PIO; slot 0 = [7:0], slot 1 = [15:8]; 0x00 = no key.
REQ-007 move_valid  output  1  a move command is pending.
REQ-008 move_dir  output  2  move direction: 00 up, 01 down, 10 left, 11 right; valid while move_valid=1.
REQ-009 move_ack  input  1  the game logic consumes the pending move.
REQ-010 paused  output  1  pause state; toggled by the Space key.
REQ-011 start_pulse  output  1  one-cycle start request; generated by the Enter key.
REQ-012 drop_count  output  8  count of moves dropped because a move was already pending; saturates.

Function
REQ-013 Synchronize frame_clk through 2 flops, then detect its rising edge; the frame tick is one Clk cycle wide.
REQ-014 Sample keycode only on the frame tick; all key decoding uses that sample.
REQ-015 Key codes:
  - Up: W 0x1A or Up-arrow 0x52
  - Down: S 0x16 or Down-arrow 0x51
  - Left: A 0x04 or Left-arrow 0x50
  - Right: D 0x07 or Right-arrow 0x4F
  - Space: 0x2C
  - Enter: 0x28
REQ-016 Direction selection: if slot 0 holds a direction key, use it; otherwise use slot 1. Other codes are ignored for direction.
REQ-017 Repeat FSM states: IDLE, DELAY, REPEAT. It advances only on frame ticks and holds a 6-bit frame counter and the current direction.
REQ-018 IDLE: a direction is present -> generate a move, load counter = REPEAT_DELAY, go to DELAY.
REQ-019 DELAY and REPEAT, on each tick:
  - no direction -> go to IDLE, no move generated;
  - different direction -> generate a move, reload REPEAT_DELAY, go to DELAY;
  - same direction -> decrement the counter; on reaching 0, generate a move, load REPEAT_PERIOD, go to (or stay in) REPEAT.
REQ-020 Move buffer is one entry:
  - a generated move sets move_valid and move_dir on the cycle after the tick;
  - the entry clears on the cycle after a cycle where move_valid=1 and move_ack=1;
  - move_ack while move_valid=0 is ignored.
REQ-021 If a move is generated while move_valid=1 and move_ack=0 in the same cycle, discard the new move, keep move_dir, and increment drop_count. drop_count saturates at 0xFF.
REQ-022 If a move is generated in the same cycle move_ack clears the entry, the new move is loaded; move_valid stays 1 and nothing is dropped.
REQ-023 While paused=1: the FSM is forced to IDLE, no moves are generated, and a pending move stays until acknowledged.
REQ-024 Space press: Space absent in the previous tick's sample and present in the current one (either slot) toggles paused on the cycle after the tick. Holding Space does not re-toggle.
REQ-025 Enter press: the same edge rule as Space raises start_pulse for exactly one cycle, on the cycle after the tick. Enter also clears paused.
REQ-026 Key edge history (previous Space/Enter presence) updates every tick, including while paused.

Reset
REQ-027 While Reset=1 on a clock edge, the following clear to 0:
  - move_valid, move_dir, paused, start_pulse, drop_count;
  - FSM (to IDLE), frame counter, direction register;
  - Space/Enter history and frame_clk synchronizer flops.
REQ-028 Reset asserted mid-repeat or with a move pending discards all state, with no residual pulse after release.
REQ-029 After release, the first tick with a key held counts as a fresh press.

Verification
REQ-030 Hold keycode=0x001A with move_ack tied high and REPEAT_DELAY=20, REPEAT_PERIOD=8: a move with dir 00 follows tick 1, then ticks 21, 29, 37; release gives no further moves.
REQ-031 keycode=0x0704 (slot 0 Left, slot 1 Right): dir 10 only. Switching to 0x0007 on the next tick gives an immediate dir 11 move and restarts the delay.
REQ-032 move_ack held low, W held for 40 ticks: one move pending (dir 00); drop_count=2 after repeats at ticks 21 and 29; ack then clears move_valid the next cycle.
REQ-033 Space held 5 ticks: paused toggles 0->1 once; W then yields no moves. Enter press: start_pulse high 1 cycle and paused=0.
REQ-034 Reset pulsed 1 cycle during REPEAT with move_valid=1: all outputs 0 the next cycle; W still held gives a move on the first tick after release.
REQ-035 Move generated in the same cycle as move_ack: move_valid stays 1 with the new dir, and drop_count is unchanged.
